preamble_inserter_wide: RTL
===========================

# preamble_inserter_wide

Parametrised TX-path block that prepends the PHY-specific BLE preamble to an AXI-Stream bit stream (access address onward) carried in beats of `DataWidth` bits. It sits between the access-address/packet assembler and the modulator-side serializer in the baseband TX chain. After the preamble, it sustains full throughput of one beat per cycle with correct backpressure. It also adds abort-on-restart and busy/done status.

## Interface

Parameters:
- `DataWidth`, default 1: bits per beat; legal values 1, 2, 4, 8; elaboration error otherwise.

Ports:
- `aclk`, in, 1: clock.
- `aresetn`, in, 1: reset, synchronous, active-low; clock `aclk`.
- `restart`, in, 1: arms the block for a new packet and aborts any packet in flight.
- `phy`, in, `ble_phy_t`: PHY select; sampled only at first-beat capture.
- `input_tdata`, in, `DataWidth`: bit 0 is transmitted first.
- `input_tvalid`, in, 1: input beat valid.
- `input_tready`, out, 1: input beat accepted when high with `input_tvalid`.
- `input_tlast`, in, 1: marks the last beat of the packet.
- `output_tdata`, out, `DataWidth`: same bit order as input.
- `output_tvalid`, out, 1: output beat valid.
- `output_tready`, in, 1: downstream accepts the beat.
- `output_tlast`, out, 1: marks the last beat of the packet.
- `busy`, out, 1: high in every state except Idle.
- `done`, out, 1: one-cycle pulse when a beat with `output_tlast` is accepted.

## Operation

- States:
  - **Idle**: `input_tready`=0 and `output_tvalid`=0.
    - `restart` → Armed.
  - **Armed**: `input_tready`=1.
    - On the first accepted beat:
      - latch the beat into `hold_data`/`hold_last`;
      - latch `phy`;
      - load the pattern for that PHY;
      - drive preamble beat 0;
      - `counter`←1;
      - go to Preamble.
  - **Preamble**: each output handshake advances one beat, `pattern[counter*W +: W]`, with `output_tlast`=0.
    - After the last preamble beat is accepted, output the held beat and go to Data.
  - **Data**: `input_tready = !output_tvalid || output_tready`, combinational.
    - An accepted input beat is registered onto the output in the next cycle, with no bubbles.
    - Acceptance of an output beat with `tlast` → Idle.
- Patterns, index 0 transmitted first:
  - 1M: 8 bits, alternating; bit 0 equals the access-address first bit (`input_tdata[0]` of the captured beat). Value is 0xAA if that bit is 0, else 0x55.
  - 2M: 16 bits, same rule (0xAAAA / 0x5555).
  - Coded: 80 bits, `{10{8'b00111100}}`, independent of data.
  - Any other `phy` encoding is treated as 1M.
- Preamble beat count = pattern length / `DataWidth` (exact for all legal widths).
- `counter` is 7 bits and counts beats, not bits.
- Single-beat packet (`tlast` on the captured beat): the held beat is emitted with `output_tlast`=1 after the preamble, then Idle. No further input is accepted.
- `restart` has priority over all other events in the same cycle. It forces Armed, and in that same next cycle it:
  - clears `output_tvalid`/`output_tlast`;
  - discards the held beat;
  - does not assert `done`.

  Mid-packet restart deliberately truncates the stream. Downstream treats `restart` as a packet abort.
- Input beats offered in Idle or Preamble are not accepted (`input_tready`=0).

## Timing

- Reset values:
  - outputs: `output_tvalid`=0, `output_tdata`=0, `output_tlast`=0, `input_tready`=0, `busy`=0, `done`=0;
  - internal: state Idle, `counter`=0, hold registers 0.
- `restart` at cycle N → state Armed and `input_tready`=1 at N+1.
- Capture at cycle M → preamble beat 0 valid at M+1.
- With `output_tready` held high:
  - preamble occupies cycles M+1 … M+P (P = beat count);
  - held beat at M+P+1;
  - subsequent input beats follow one per cycle.
- Latency in Data is one register stage; the output holds stable while `output_tvalid && !output_tready`.
- `done` is asserted the cycle after the final output handshake. `busy` falls in that same cycle.
- Total output beats for a K-beat input packet = P + K.

## Structure

- The `ble_types` shared package holds:
  - `ble_phy_t`;
  - preamble length constants: 8, 16, 80 bits;
  - preamble pattern constants: 0xAA, 0xAAAA, `{10{8'b00111100}}`.
- Pattern and length selection are package functions, `ble_preamble_pattern(phy, first_bit)` and `ble_preamble_len(phy)`, reused by RX correlators.
- Single module; no sub-module required. The Data-state output register is the only pipeline stage.

## Test plan

- W=1, 1M, 32-bit AA 0x8E89BED6 (LSB first, first bit 0), ready always 1 → output is 8 bits 0,1,0,1,0,1,0,1 then the AA bits, 40 beats total, `done` once.
- W=4, 2M, first nibble 0x7 → 4 preamble beats of 0xA… with bit 0 = 1, i.e. 0x5 each, then data unchanged at one beat/cycle; `tlast` preserved.
- W=8, Coded, 5-beat packet, random `output_tready` (50%) → 10 beats of 0x3C then 5 data beats. No beat lost or duplicated; output stable during stalls.
- W=2, 1M, single-beat packet with `tlast` → 4 preamble beats + 1 beat with `output_tlast`=1; `input_tready`=0 afterward; Idle.
- W=1, `restart` asserted mid-Data (beat 20) → next cycle `output_tvalid`=0, Armed, no `done`. A new packet then produces a correct preamble with polarity from its own first bit.
- Reset mid-Preamble → all outputs reach reset values next cycle. `input_tvalid` offered in Idle is never accepted.

Source files
------------

// File: rtl/ble_types_pkg.sv
// Shared BLE baseband types: PHY select, preamble lengths/patterns and the
// helpers that pick them, used by TX preamble insertion and RX correlators.
package ble_types;

    typedef enum logic [1:0] {
        BLE_PHY_1M    = 2'd0,
        BLE_PHY_2M    = 2'd1,
        BLE_PHY_CODED = 2'd2
    } ble_phy_t;

    localparam int unsigned BLE_PREAMBLE_LEN_1M    = 8;
    localparam int unsigned BLE_PREAMBLE_LEN_2M    = 16;
    localparam int unsigned BLE_PREAMBLE_LEN_CODED = 80;
    localparam int unsigned BLE_PREAMBLE_LEN_MAX   = 80;

    localparam logic [7:0]  BLE_PREAMBLE_1M    = 8'hAA;
    localparam logic [15:0] BLE_PREAMBLE_2M    = 16'hAAAA;
    localparam logic [79:0] BLE_PREAMBLE_CODED = {10{8'b00111100}};

    // Uncoded preambles alternate starting with the access-address first bit;
    // the base constants start with 0, so a first bit of 1 inverts them.
    function automatic logic [79:0] ble_preamble_pattern(input ble_phy_t phy, input logic first_bit);
        logic [79:0] pattern;
        pattern = '0;
        case (phy)
            BLE_PHY_2M:    pattern[15:0] = first_bit ? ~BLE_PREAMBLE_2M : BLE_PREAMBLE_2M;
            BLE_PHY_CODED: pattern       = BLE_PREAMBLE_CODED;
            default:       pattern[7:0]  = first_bit ? ~BLE_PREAMBLE_1M : BLE_PREAMBLE_1M;
        endcase
        return pattern;
    endfunction

    function automatic logic [6:0] ble_preamble_len(input ble_phy_t phy);
        logic [6:0] len;
        case (phy)
            BLE_PHY_2M:    len = 7'(BLE_PREAMBLE_LEN_2M);
            BLE_PHY_CODED: len = 7'(BLE_PREAMBLE_LEN_CODED);
            default:       len = 7'(BLE_PREAMBLE_LEN_1M);
        endcase
        return len;
    endfunction

endpackage

// File: rtl/preamble_inserter_wide.sv
// Prepends the PHY-specific BLE preamble to an AXI-Stream packet carried in
// DataWidth-bit beats, then streams the packet through one register stage.
module preamble_inserter_wide
    import ble_types::*;
#(
    parameter int DataWidth = 1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 restart,
    input  ble_phy_t             phy,
    input  logic [DataWidth-1:0] input_tdata,
    input  logic                 input_tvalid,
    output logic                 input_tready,
    input  logic                 input_tlast,
    output logic [DataWidth-1:0] output_tdata,
    output logic                 output_tvalid,
    input  logic                 output_tready,
    output logic                 output_tlast,
    output logic                 busy,
    output logic                 done
);

    generate
        if (!(DataWidth == 1 || DataWidth == 2 || DataWidth == 4 || DataWidth == 8)) begin : g_bad_width
            $error("preamble_inserter_wide: DataWidth must be 1, 2, 4 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_PREAMBLE,
        ST_DATA
    } state_t;

    state_t               state_q, state_d;
    logic [6:0]           counter_q, counter_d;
    ble_phy_t             phy_q, phy_d;
    logic [79:0]          pattern_q, pattern_d;
    logic [DataWidth-1:0] hold_data_q, hold_data_d;
    logic                 hold_last_q, hold_last_d;
    logic [DataWidth-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 done_q, done_d;

    logic [79:0] capture_pattern;
    logic [6:0]  preamble_beats;
    logic        in_fire;
    logic        out_fire;

    assign capture_pattern = ble_preamble_pattern(phy, input_tdata[0]);
    assign preamble_beats  = ble_preamble_len(phy_q) / 7'(DataWidth);
    assign in_fire         = input_tvalid && input_tready;
    assign out_fire        = out_valid_q && output_tready;

    // Once the final beat sits in the output register no more input is taken,
    // otherwise the next packet's first beat would slip into this one.
    always_comb begin
        input_tready = 1'b0;
        case (state_q)
            ST_ARMED: input_tready = 1'b1;
            ST_DATA:  input_tready = (!out_valid_q || output_tready) && !out_last_q;
            default:  input_tready = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        phy_d       = phy_q;
        pattern_d   = pattern_q;
        hold_data_d = hold_data_q;
        hold_last_d = hold_last_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        if (restart) begin
            state_d     = ST_ARMED;
            counter_d   = '0;
            hold_data_d = '0;
            hold_last_d = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (in_fire) begin
                        hold_data_d = input_tdata;
                        hold_last_d = input_tlast;
                        phy_d       = phy;
                        pattern_d   = capture_pattern;
                        out_data_d  = capture_pattern[DataWidth-1:0];
                        out_valid_d = 1'b1;
                        out_last_d  = 1'b0;
                        counter_d   = 7'd1;
                        state_d     = ST_PREAMBLE;
                    end
                end
                ST_PREAMBLE: begin
                    if (out_fire) begin
                        if (counter_q == preamble_beats) begin
                            out_data_d = hold_data_q;
                            out_last_d = hold_last_q;
                            state_d    = ST_DATA;
                        end else begin
                            out_data_d = pattern_q[counter_q*DataWidth +: DataWidth];
                            counter_d  = counter_q + 7'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (out_fire && out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_IDLE;
                    end else if (in_fire) begin
                        out_data_d  = input_tdata;
                        out_last_d  = input_tlast;
                        out_valid_d = 1'b1;
                    end else if (out_fire) begin
                        out_valid_d = 1'b0;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_IDLE;
            counter_q   <= '0;
            phy_q       <= BLE_PHY_1M;
            pattern_q   <= '0;
            hold_data_q <= '0;
            hold_last_q <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            phy_q       <= phy_d;
            pattern_q   <= pattern_d;
            hold_data_q <= hold_data_d;
            hold_last_q <= hold_last_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign output_tdata  = out_data_q;
    assign output_tvalid = out_valid_q;
    assign output_tlast  = out_last_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;

endmodule
